// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: word width, base opcodes,
// fetch-stage state encoding and the fetch buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundles of the fetch stage: instruction-memory request/response
// channel and the valid/ready channel towards decode.
interface imem_if;
  logic                       imem_req;
  logic [riscv_pkg::XLEN-1:0] imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [riscv_pkg::XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

interface dec_if;
  logic                       if_valid;
  logic                       if_ready;
  logic [riscv_pkg::XLEN-1:0] if_instr;
  logic [riscv_pkg::XLEN-1:0] if_pc;
  logic [6:0]                 if_opcode;

  modport master (output if_valid, if_instr, if_pc, if_opcode, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, if_opcode, output if_ready);
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc}; a push into a full buffer is taken only
// when a pop frees the head in the same cycle. Clear wins over everything.
module fetch_buffer (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [2*riscv_pkg::XLEN-1:0] wdata,
  output logic [2*riscv_pkg::XLEN-1:0] rdata,
  output logic                         full,
  output logic                         empty
);

  logic [2*riscv_pkg::XLEN-1:0] mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop, wr_en;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_en   = do_push && !clear;
  // Empty buffer presents zeros so decode never sees a stale word.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order word fetches, tags responses with
// their PC, buffers up to two instructions and restarts cleanly on redirect.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_if.master          imem,
  dec_if.master           dec,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      out_q, out_d;
  logic [XLEN-1:0] pcq_q [2];
  logic [XLEN-1:0] pcq_d [2];

  logic            accept, rsp_ok, slot;
  logic            buf_push, buf_pop, buf_full, buf_empty;
  logic [1:0]      occ;
  logic [2*XLEN-1:0] buf_rdata;
  fetch_entry_t    wentry, head;

  // Outstanding requests plus buffered words never exceed the buffer size,
  // so every response always has a slot waiting for it.
  assign occ    = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
  assign imem.imem_req  = (state_q == FS_RUN) && !redirect_valid &&
                          ((int'(out_q) + int'(occ)) < BUF_DEPTH);
  assign imem.imem_addr = pc_q;
  assign accept = imem.imem_req && imem.imem_gnt;
  assign rsp_ok = imem.imem_rvalid && (out_q != 2'd0);

  assign dec.if_valid = !buf_empty && !redirect_valid;
  assign buf_pop      = dec.if_valid && dec.if_ready;
  assign buf_push     = rsp_ok && (state_q == FS_RUN) && !redirect_valid;

  assign wentry        = '{instr: imem.imem_rdata, pc: pcq_q[0]};
  assign head          = fetch_entry_t'(buf_rdata);
  assign dec.if_instr  = head.instr;
  assign dec.if_pc     = head.pc;
  assign dec.if_opcode = head.instr[6:0];

  // Slot for a newly accepted PC: behind whatever is still in flight
  // after this cycle's response retires.
  assign slot = (out_q == 2'd1) && !rsp_ok;

  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q + {1'b0, accept} - {1'b0, rsp_ok};
    pcq_d   = pcq_q;
    state_d = state_q;
    if (rsp_ok) pcq_d[0] = pcq_q[1];
    if (accept) begin
      pc_d        = pc_q + 32'd4;
      pcq_d[slot] = pc_q;
    end
    if (redirect_valid) pc_d = align_word(redirect_pc);
    case (state_q)
      FS_IDLE:  state_d = FS_RUN;
      FS_RUN:   if (redirect_valid && out_d != 2'd0) state_d = FS_FLUSH;
      // While flushing, the outstanding counter doubles as the discard count.
      FS_FLUSH: if (out_d == 2'd0) state_d = FS_RUN;
      default:  state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      out_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    pcq_q <= pcq_d;
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (redirect_valid),
    .wdata (wentry),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Responses with nothing in flight are a protocol error; in IDLE they can
  // only be leftovers of requests abandoned by reset, which are expected.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    (imem.imem_rvalid && state_q != FS_IDLE) |-> (out_q != 2'd0));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a memory responder model, an expected-PC
// scoreboard checked on every decode pop, and directed scenario checks.
module tb_if_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  imem_if imem ();
  dec_if  dec ();

  if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .dec            (dec),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          errs = 0;
  int          chks = 0;
  int          cyc = 0;
  bit          mem_hold = 1'b0;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Memory: answers in order, one cycle after accept at the earliest.
  always @(negedge clk) begin
    #1;
    imem.imem_rvalid = 1'b0;
    if (!mem_hold && pend.size() > 0 && pend[0].due <= cyc) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end
    if (imem.imem_req && imem.imem_gnt) begin
      pend.push_back('{imem.imem_addr, cyc + 1});
      acc_log.push_back(imem.imem_addr);
    end
  end

  // Scoreboard monitor: every handshake to decode is checked against exp_q.
  always @(negedge clk) begin
    logic [31:0] e, ei;
    #1;
    if (rst_n && dec.if_valid && dec.if_ready) begin
      if (exp_q.size() == 0) begin
        chks++;
        errs++;
        $display("FAIL unexpected_pop: got pc %h, required no instruction", dec.if_pc);
      end else begin
        e  = exp_q.pop_front();
        ei = instr_of(e);
        check("pop_pc", dec.if_pc, e);
        check("pop_instr", dec.if_instr, ei);
        check("pop_opcode", {25'd0, dec.if_opcode}, {25'd0, ei[6:0]});
      end
    end
  end

  task automatic wait_acc(input int target, input string name);
    int k;
    k = 0;
    while (acc_log.size() < target && k < 40) begin
      @(negedge clk);
      #2;
      k++;
    end
    check(name, 32'(acc_log.size()), 32'(target));
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && k < 60) begin
      @(negedge clk);
      #2;
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(imem.imem_req), 32'd0);
    check({tag, "_valid"},  32'(dec.if_valid),  32'd0);
    check({tag, "_instr"},  dec.if_instr,       32'd0);
    check({tag, "_pc"},     dec.if_pc,          32'd0);
    check({tag, "_opcode"}, 32'(dec.if_opcode), 32'd0);
    check({tag, "_addr"},   imem.imem_addr,     RST_PC);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errs, chks);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    imem.imem_gnt = 1'b0;
    dec.if_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("rst");

    // Straight-line fetch: 0, 4, 8
    @(negedge clk);
    base = acc_log.size();
    rst_n = 1'b1;
    imem.imem_gnt = 1'b1;
    dec.if_ready  = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    #2;
    check("idle_req", 32'(imem.imem_req), 32'd0);
    wait_acc(base + 3, "t32_acc");
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    wait_drain("t32_drain");
    check("t32_a0", acc_log[base],     32'h0);
    check("t32_a1", acc_log[base + 1], 32'h4);
    check("t32_a2", acc_log[base + 2], 32'h8);

    // Decode stall: two fetches fill the buffer, then fetching stops
    @(negedge clk);
    base = acc_log.size();
    dec.if_ready  = 1'b0;
    imem.imem_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (i == 4) begin
        check("t33_hold_pc",    dec.if_pc,    32'hC);
        check("t33_hold_instr", dec.if_instr, instr_of(32'hC));
      end
    end
    check("t33_accepts", 32'(acc_log.size() - base), 32'd2);
    check("t33_req_low", 32'(imem.imem_req),         32'd0);
    check("t33_valid",   32'(dec.if_valid),          32'd1);
    check("t33_pc",      dec.if_pc,                  32'hC);
    check("t33_instr",   dec.if_instr,               instr_of(32'hC));
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    dec.if_ready = 1'b1;
    wait_drain("t33_drain");

    // Redirect with two requests in flight
    @(negedge clk);
    base = acc_log.size();
    mem_hold = 1'b1;
    imem.imem_gnt = 1'b1;
    wait_acc(base + 2, "t34_acc2");
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    mem_hold       = 1'b0;
    exp_q.push_back(32'h100);
    #2;
    check("t34_redir_req", 32'(imem.imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("t34_flush_req",  32'(imem.imem_req), 32'd0);
    check("t34_flush_addr", imem.imem_addr,     32'h100);
    wait_acc(base + 3, "t34_acc3");
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    wait_drain("t34_drain");
    check("t34_a2", acc_log[base + 2], 32'h100);

    // Redirect coincident with a pop and a response
    @(negedge clk);
    base = acc_log.size();
    dec.if_ready  = 1'b0;
    imem.imem_gnt = 1'b1;
    wait_acc(base + 2, "t35_acc2");
    @(negedge clk);
    check("t35_pre_valid", 32'(dec.if_valid), 32'd1);
    check("t35_pre_pc",    dec.if_pc,         32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    dec.if_ready   = 1'b1;
    exp_q.push_back(32'h200);
    #2;
    check("t35_forced_low", 32'(dec.if_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("t35_empty", 32'(dec.if_valid),  32'd0);
    check("t35_req",   32'(imem.imem_req), 32'd1);
    check("t35_addr",  imem.imem_addr,     32'h200);
    wait_acc(base + 3, "t35_acc3");
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    wait_drain("t35_drain");

    // Unaligned redirect to the top word, then wrap to zero
    @(negedge clk);
    base = acc_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    imem.imem_gnt  = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("t36_addr", imem.imem_addr, 32'hFFFF_FFFC);
    wait_acc(base + 2, "t36_acc");
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    wait_drain("t36_drain");
    check("t36_a0", acc_log[base],     32'hFFFF_FFFC);
    check("t36_a1", acc_log[base + 1], 32'h0);

    // Reset with one request in flight and one buffered word
    @(negedge clk);
    base = acc_log.size();
    dec.if_ready  = 1'b0;
    imem.imem_gnt = 1'b1;
    wait_acc(base + 2, "t37_acc2");
    @(negedge clk);
    mem_hold      = 1'b1;
    imem.imem_gnt = 1'b0;
    #2;
    check("t37_pre_valid", 32'(dec.if_valid),  32'd1);
    check("t37_pre_pc",    dec.if_pc,          32'h4);
    check("t37_pre_addr",  imem.imem_addr,     32'hC);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t37_rst");
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    mem_hold      = 1'b0;
    imem.imem_gnt = 1'b1;
    dec.if_ready  = 1'b1;
    exp_q.push_back(RST_PC);
    exp_q.push_back(RST_PC + 32'h4);
    wait_acc(base + 4, "t37_acc");
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    wait_drain("t37_drain");
    check("t37_first_addr", acc_log[base + 2], RST_PC);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: BUF_DEPTH, 2, entries in the instruction buffer; fixed at 2.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: imem_req  output  1  fetch request valid.
REQ-006 Port: imem_addr  output  32  fetch address, word aligned.
REQ-007 Port: imem_gnt  input  1  request accepted this cycle (imem_req & imem_gnt = accept).
REQ-008 Port: imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after accept.
REQ-009 Port: imem_rdata  input  32  instruction word.
REQ-010 Port: redirect_valid  input  1  branch/jal taken; restart fetch.
REQ-011 Port: redirect_pc  input  32  new fetch address.
REQ-012 Port: if_valid  output  1  instruction available to decode.
REQ-013 Port: if_ready  input  1  decode accepts (if_valid & if_ready = pop).
REQ-014 Port: if_instr  output  32  instruction word.
REQ-015 Port: if_pc  output  32  address of if_instr.
REQ-016 Port: if_opcode  output  7  if_instr[6:0]; feeds the control decoder's Opcode input.

Function
REQ-017 imem_addr SHALL equal the fetch PC register; PC SHALL advance by 4 on each accept, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 imem_req SHALL assert only in RUN and only when outstanding + buffer occupancy < 2; the buffer can then never overflow.
REQ-019 The outstanding counter (0..2) SHALL increment on accept, decrement on imem_rvalid, and stay unchanged when both occur.
REQ-020 In RUN, each imem_rvalid SHALL write {rdata, pc_of_request} to the buffer; the entry SHALL be visible on if_* the next cycle (rvalid-to-if_valid latency 1).
REQ-021 if_valid SHALL equal buffer non-empty; if_instr/if_pc SHALL hold steady while if_valid & !if_ready.
REQ-022 Write and pop in the same cycle SHALL both take effect, including with the buffer full.
REQ-023 States: IDLE -> RUN unconditionally one cycle after reset release; RUN -> FLUSH on redirect_valid with outstanding (after that cycle's accept/response) > 0; RUN -> RUN on redirect with none outstanding; FLUSH -> RUN when the discard count reaches 0.
REQ-024 On redirect_valid (any state): PC <= redirect_pc, buffer cleared, if_valid forced low that cycle, no pop counted, imem_req low that cycle.
REQ-025 In FLUSH, imem_req SHALL be low and each imem_rvalid SHALL be discarded, decrementing the discard count; a further redirect in FLUSH SHALL update PC only.
REQ-026 imem_rvalid with zero outstanding SHALL be ignored (protocol error, flagged by assertion).
REQ-027 An unaligned redirect_pc SHALL have bits [1:0] forced to 0.

Reset
REQ-028 While rst_n=0: state IDLE, PC=RESET_PC, outstanding=0, buffer empty, imem_req=0, if_valid=0, if_instr/if_pc=0, if_opcode=0.
REQ-029 Reset asserted mid-operation SHALL abandon all in-flight requests; responses for them arriving after release SHALL be ignored per REQ-026.

Structure
REQ-030 Shared package riscv_pkg SHALL hold XLEN=32, the opcode constants (R-type 0110011, load 0000011, store 0100011, branch 1100011, I-ALU 0010011, jal 1101111) and the fetch-state enum.
REQ-031 The 2-entry FIFO SHALL be a sub-module named fetch_buffer (push, pop, clear, full, empty, 64-bit data).

Verification
REQ-032 Reset release, imem_gnt=1, rvalid 1 cycle after each accept, if_ready=1 -> addresses 0,4,8 issued back-to-back; if_pc sequence 0,4,8.
REQ-033 if_ready=0 for 10 cycles -> exactly 2 accepts, buffer full, imem_req=0, if_instr stable; on release, order preserved with no loss.
REQ-034 redirect_valid with redirect_pc=32'h0000_0100 while 2 outstanding -> FLUSH; both stale responses dropped; next if_pc=32'h100.
REQ-035 redirect coincident with a pop and an rvalid -> buffer empty next cycle, nothing from the old path ever presented.
REQ-036 redirect_pc=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
REQ-037 rst_n pulsed low with 1 request outstanding -> outputs reach reset values immediately; late rvalid ignored; first if_pc=RESET_PC.
